// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths, state/grant encodings and pointer helper for the RF port arbiter
package rf_arb_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    typedef enum logic {CLEAR, RUN} state_e;
    typedef enum logic [1:0] {GNT_R, GNT_W0, GNT_W1, GNT_NONE} gnt_e;
    function automatic gnt_e next_gnt(input gnt_e g);
        return g == GNT_R ? GNT_W0 : g == GNT_W0 ? GNT_W1 : GNT_R;
    endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin picker with a pointer that advances past each grant
module rr_arbiter3
    import rf_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt
);
    gnt_e ptr, o1, o2, pick;
    always_comb begin
        o1 = next_gnt(ptr);
        o2 = next_gnt(o1);
        pick = req[ptr] ? ptr : req[o1] ? o1 : req[o2] ? o2 : GNT_NONE;
        gnt = pick == GNT_NONE ? 3'b000 : 3'b001 << pick;
    end
    always_ff @(posedge clk)
        if (reset) ptr <= GNT_R;
        else if (pick != GNT_NONE) ptr <= next_gnt(pick);
endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: clears the RF after reset, then shares its port among one reader and two writers
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_ra,
    input  logic [ADDR_W-1:0] rd_rb,
    output logic              rd_ready,
    output logic              rd_dvalid,
    output logic [DATA_W-1:0] rd_da,
    output logic [DATA_W-1:0] rd_db,
    input  logic              w0_valid,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_ready,
    input  logic              w1_valid,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_ready,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    output logic              rf_wr_en,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    output logic              init_done
);
    localparam int NREGS = 2 ** ADDR_W;
    state_e state;
    logic [ADDR_W-1:0] idx;
    logic [2:0] req, gnt;
    logic clr, run;
    assign clr = state == CLEAR && !reset;
    assign run = state == RUN && !reset;
    assign req = run ? {w1_valid, w0_valid, rd_valid} : 3'b000;
    rr_arbiter3 u_arb (
        .clk(clk),
        .reset(reset),
        .req(req),
        .gnt(gnt)
    );
    assign {w1_ready, w0_ready, rd_ready} = gnt;
    always_comb begin
        rf_wr_en = clr | gnt[1] | gnt[2];
        rf_addr1 = clr ? idx : gnt[0] ? rd_ra : gnt[1] ? w0_addr : gnt[2] ? w1_addr : '0;
        rf_addr2 = gnt[0] ? rd_rb : '0;
        rf_wr_data = gnt[1] ? w0_data : gnt[2] ? w1_data : '0;
    end
    always_ff @(posedge clk)
        if (reset) begin
            state <= CLEAR;
            idx <= '0;
            init_done <= 1'b0;
            rd_dvalid <= 1'b0;
            rd_da <= '0;
            rd_db <= '0;
        end else begin
            if (clr) begin
                idx <= idx + 1'b1;
                if (idx == ADDR_W'(NREGS - 1)) begin
                    state <= RUN;
                    init_done <= 1'b1;
                end
            end
            rd_dvalid <= gnt[0];
            if (gnt[0]) begin
                rd_da <= rf_rd_data1;
                rd_db <= rf_rd_data2;
            end
        end
endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Shares the single write/read-1 address port of the 16-bit register file (RF) between one read requester (operand fetch) and two write requesters (ALU writeback, load/debug writeback). After reset it runs a clear sequence that zeroes every register. It sits between the datapath control and the RF instance, and drives all RF address, data and write-enable inputs.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 4, register address width; NREGS = 2**ADDR_W
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_valid  in  1  read request pending
- rd_ra, rd_rb  in  ADDR_W  operand addresses
- rd_ready  out  1  read granted this cycle
- rd_dvalid  out  1  registered read data valid
- rd_da, rd_db  out  DATA_W  registered operands
- w0_valid, w1_valid  in  1  write request pending
- w0_addr, w1_addr  in  ADDR_W  write address
- w0_data, w1_data  in  DATA_W  write data
- w0_ready, w1_ready  out  1  write granted this cycle
- rf_addr1, rf_addr2  out  ADDR_W  to RF addr1/addr2
- rf_wr_en  out  1  to RF wr_en
- rf_wr_data  out  DATA_W  to RF wr_data
- rf_rd_data1, rf_rd_data2  in  DATA_W  from RF
- init_done  out  1  clear sequence complete

## Operation
- States: CLEAR, RUN. Reset → CLEAR, clear index 0.
- CLEAR: each cycle rf_wr_en=1, rf_addr1=index, rf_wr_data=0; index increments. After writing NREGS-1 → RUN. All *_ready=0 in CLEAR.
- RUN: at most one grant per cycle among R (read), W0, W1. Requesters are the 3-way round-robin order R→W0→W1. The grant goes to the first valid requester at or after pointer p. After a grant, p = granted+1 (mod 3). With no valid requester, p holds. Reset sets p=R.
- Grant W0/W1: rf_addr1=wN_addr, rf_wr_data=wN_data, rf_wr_en=1, wN_ready=1. The RF is written at that edge.
- Grant R: rf_addr1=rd_ra, rf_addr2=rd_rb, rf_wr_en=0, rd_ready=1. At that edge, rf_rd_data1/2 are captured into rd_da/rd_db and rd_dvalid is set for one cycle.
- No grant: rf_wr_en=0, rf_addr1/2=0, rf_wr_data=0.
- Handshake: a requester holds valid and its address/data stable until ready; the transfer completes in the cycle where valid & ready. Ready is combinational from valid and state, never from ready of another port.
- Ordering: writes from W0 and W1 to the same address land in grant order; the last granted value wins. A read observes all writes granted in earlier cycles. A read cannot coincide with a write, so no bypass is needed.
- Reset values: state=CLEAR, index=0, p=R, rd_dvalid=0, rd_da=rd_db=0, init_done=0. All ready outputs are 0 during the reset cycle, and rf_wr_en=0 while reset is high.
- Reset mid-CLEAR or mid-RUN: pending requests are dropped without acknowledgement, and the clear restarts at index 0.

## Timing
- Write latency: RF updated at the edge ending the grant cycle.
- Read latency: rd_dvalid/rd_da/rd_db valid 1 cycle after the rd_ready cycle.
- Clear: NREGS cycles after reset deasserts; init_done rises on the first RUN cycle.
- Worst-case wait for a continuously valid requester: 2 cycles (fairness bound).

## Structure
- Package rf_arb_pkg: DATA_W/ADDR_W defaults, state enum {CLEAR, RUN}, grant enum {GNT_R, GNT_W0, GNT_W1, GNT_NONE}.
- Sub-module rr_arbiter3: pointer register plus combinational first-valid picker. Outputs a one-hot grant; the pointer advances on grant.
- The top-level arbiter holds the CLEAR counter, output muxing and read-data registers. The RF is instantiated by the parent.

## Test plan
- Reset then hold all valids high: 16 cycles of rf_wr_en with addr 0..15 and data 0; no ready during these cycles. init_done=1 at cycle 16, and all registers read 0.
- W0 alone, addr 5, data 1000 → w0_ready the same cycle; registers[5]=1000 after the edge. Other registers are unchanged.
- R, W0 and W1 all continuously valid from the pointer reset → grants R, W0, W1, R, W0, W1; each requester is acked every 3rd cycle.
- Write reg 6=42, then read ra=5, rb=6 → rd_dvalid one cycle after rd_ready, with rd_da=1000 and rd_db=42. A read with ra=rb=5 → both outputs are 1000.
- W0 (reg 3=7) and W1 (reg 3=9) valid together with p=W1 → W1 is granted first and W0 next; the final registers[3]=7.
- Assert reset at clear index 7 → after reset drops, the clear restarts at address 0 and init_done stays low for 16 cycles. A pending w1_valid is never acknowledged before init_done.
